id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the register file.
- Captures ReadData1/ReadData2, register numbers, immediate, PC+4 and decode control into the ID/EX register.
- Bypasses same-cycle write-back data into the captured operands.
- Detects load-use hazards, raises a stall to PC/IF-ID and inserts a bubble; counts stall cycles for performance debug.

Parameters:
- DATA_WIDTH, 32, width of register data, immediate and PC.
- CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
ReadData1_i  in  DATA_WIDTH  register file port 1 data (rs)
ReadData2_i  in  DATA_WIDTH  register file port 2 data (rt)
Rs_i  in  5  rs field of the instruction in ID
Rt_i  in  5  rt field
Rd_i  in  5  rd field
Imm_i  in  DATA_WIDTH  sign-extended immediate
PC4_i  in  DATA_WIDTH  PC+4 of the instruction in ID
RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i, RegDst_i  in  1 each  decode control
ALUOp_i  in  3  ALU operation class
ID_Valid_i  in  1  ID holds a real instruction
Flush_i  in  1  branch/jump taken; kill the instruction entering EX
WB_RegWrite_i  in  1  write-back stage is writing the register file this cycle
WB_WriteRegister_i  in  5  write-back destination
WB_WriteData_i  in  DATA_WIDTH  write-back data
Stall_o  out  1  combinational; hold PC and IF/ID
EX_ReadData1_o, EX_ReadData2_o, EX_Imm_o, EX_PC4_o  out  DATA_WIDTH  registered operands
EX_Rs_o, EX_Rt_o, EX_WriteRegister_o  out  5  registered register numbers
EX_RegWrite_o, EX_MemRead_o, EX_MemWrite_o, EX_MemtoReg_o, EX_ALUSrc_o  out  1  registered control
EX_ALUOp_o  out  3  registered ALU op
EX_Valid_o  out  1  EX holds a real instruction
StallCount_o  out  CNT_WIDTH  saturating count of stall cycles

Behaviour:
- Reset (reset=0, asynchronous): every EX_* output and StallCount_o are 0. Stall_o is 0 because EX_MemRead_o=0.
- Load-use hazard: Stall_o = EX_MemRead_o & EX_Valid_o & ID_Valid_i & (EX_WriteRegister_o != 0) & (EX_WriteRegister_o == Rs_i | EX_WriteRegister_o == Rt_i).
  - The rt comparison is conservative for I-type instructions; this is accepted.
- Bypass, evaluated before capture:
  - D1 = WB_WriteData_i if WB_RegWrite_i & WB_WriteRegister_i != 0 & WB_WriteRegister_i == Rs_i; otherwise ReadData1_i.
  - D2 is formed the same way, using Rt_i.
  - A write-back to register 0 is never bypassed.
- Destination register: EX_WriteRegister_o is captured as Rd_i if RegDst_i=1, else Rt_i.
- Each rising clock edge, first matching rule applies:
  1. Flush_i=1: bubble.
  2. Stall_o=1: bubble. The ID instruction is held upstream and re-presented next cycle.
  3. Otherwise: capture all *_i fields (with D1/D2 and the dest mux); EX_Valid_o = ID_Valid_i.
- Bubble: RegWrite, MemRead, MemWrite, MemtoReg, Valid and ALUOp go to 0. Data and register-number outputs may hold or load; they are don't-care when EX_Valid_o=0.
- Latency: one cycle from ID inputs to EX_* outputs.
- A single load-use hazard stalls for exactly one cycle. After the bubble EX_MemRead_o=0, so Stall_o deasserts.
- StallCount_o increments on every edge where Stall_o=1 and saturates at all-ones (no wrap).
- Simultaneous Flush_i and Stall_o: flush wins. The stall still counts, and Stall_o stays asserted combinationally that cycle.
- ID_Valid_i=0 with no flush or stall: capture proceeds with EX_Valid_o=0 and control outputs as presented. Downstream gates on EX_Valid_o.
- Reset asserted mid-operation clears state immediately, independent of clk.

Decomposition:
- Shared package:
  - REG_ZERO = 5'd0
  - ALUOp encoding constants (3-bit)
  - control-bundle field widths
- One natural sub-module: id_ex_hazard_bypass (combinational Stall_o plus the D1/D2 bypass muxes). The top level holds the ID/EX register and the counter.

Test Plan:
1. Reset: drive reset=0 mid-run → all EX_* outputs 0, StallCount_o=0, Stall_o=0 without waiting for a clock edge.
2. Normal capture: Rs_i=8, ReadData1_i=0x11, RegDst_i=1, Rd_i=10, no WB → next edge EX_ReadData1_o=0x11, EX_WriteRegister_o=10, EX_Valid_o=1.
3. WB bypass: WB_RegWrite_i=1, WB_WriteRegister_i=9, WB_WriteData_i=0xDEAD, Rt_i=9, ReadData2_i=0 → EX_ReadData2_o=0xDEAD. Repeat with register 0 → stays 0.
4. Load-use: EX holds lw to register 16, ID Rs_i=16 → Stall_o=1 for exactly one cycle; next EX_Valid_o=0, EX_RegWrite_o=0; StallCount_o=1. Instruction captured the following cycle.
5. Flush priority: Flush_i=1 together with a load-use stall → bubble inserted, StallCount_o increments, no capture.
6. Counter saturation: with CNT_WIDTH=4, force 20 stall cycles → StallCount_o holds at 15.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg
//   Shared constants and types for the ID/EX pipeline stage:
//   register-zero encoding, ALU operation classes, the registered
//   control bundle and a small write-back match helper.
package id_ex_stage_pkg;

    localparam int         REG_ADDR_W = 5;
    localparam int         ALU_OP_W   = 3;
    localparam logic [4:0] REG_ZERO   = 5'd0;

    // ALU operation classes produced by decode. ADD is the all-zero code,
    // so a bubble's ALU op decodes as a harmless add.
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND   = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR    = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT   = 3'd5;

    // Control bundle held in the ID/EX register.
    typedef struct packed {
        logic                regWrite;
        logic                memRead;
        logic                memWrite;
        logic                memtoReg;
        logic                aluSrc;
        logic [ALU_OP_W-1:0] aluOp;
        logic                valid;
    } exCtrlT;

    localparam int CTRL_W = $bits(exCtrlT);

    // True when the write-back stage is writing srcReg this cycle.
    // Register zero is hard-wired, so a write to it is never forwarded.
    function automatic logic wbHits(input logic                  wbRegWrite,
                                    input logic [REG_ADDR_W-1:0] wbReg,
                                    input logic [REG_ADDR_W-1:0] srcReg);
        return wbRegWrite && (wbReg != REG_ZERO) && (wbReg == srcReg);
    endfunction

endpackage

// File: rtl/id_ex_hazard_bypass.sv
// id_ex_hazard_bypass
//   Combinational helper for the ID/EX stage.
//   Ports:
//     exMemRead, exValid, exWriteRegister : instruction currently in EX
//     idValid, rs, rt                     : instruction currently in ID
//     readData1, readData2                : register file read data
//     wbRegWrite, wbWriteRegister,
//     wbWriteData                         : write-back port this cycle
//     stall                               : load-use hazard detected
//     d1, d2                              : operands after write-back bypass
module id_ex_hazard_bypass
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  exMemRead,
    input  logic                  exValid,
    input  logic [REG_ADDR_W-1:0] exWriteRegister,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [DATA_WIDTH-1:0] readData1,
    input  logic [DATA_WIDTH-1:0] readData2,
    input  logic                  wbRegWrite,
    input  logic [REG_ADDR_W-1:0] wbWriteRegister,
    input  logic [DATA_WIDTH-1:0] wbWriteData,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] d1,
    output logic [DATA_WIDTH-1:0] d2
);

    logic exDestMatches;

    // rt is compared even for I-type instructions, where it is a
    // destination rather than a source; the occasional extra stall is
    // cheaper than decoding the instruction format here.
    assign exDestMatches = (exWriteRegister == rs) || (exWriteRegister == rt);

    assign stall = exMemRead && exValid && idValid &&
                   (exWriteRegister != REG_ZERO) && exDestMatches;

    // The register file reads before it is written in the same cycle, so
    // the value being written back has to be forwarded into the operands.
    assign d1 = wbHits(wbRegWrite, wbWriteRegister, rs) ? wbWriteData : readData1;
    assign d2 = wbHits(wbRegWrite, wbWriteRegister, rt) ? wbWriteData : readData2;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register with write-back bypass, load-use stall
//   detection and a saturating stall-cycle counter.
//   Ports:
//     clk, reset (async, active-low)
//     ReadData1_i/ReadData2_i, Rs_i/Rt_i/Rd_i, Imm_i, PC4_i : ID operands
//     RegWrite_i..RegDst_i, ALUOp_i, ID_Valid_i            : ID decode control
//     Flush_i                                              : kill the instruction entering EX
//     WB_RegWrite_i, WB_WriteRegister_i, WB_WriteData_i    : write-back port
//     Stall_o                                              : hold PC and IF/ID (combinational)
//     EX_*                                                 : registered ID/EX contents
//     StallCount_o                                         : saturating stall-cycle count
//
//   Flow control: EX_Valid_o qualifies every EX_* data and register-number
//   output; when it is 0 those outputs are don't-care and the control
//   outputs read as a bubble (or as presented when ID had no instruction).
//   Stall_o is the only backpressure: while it is 1 the ID instruction is
//   not consumed and must be re-presented unchanged on the next cycle.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ReadData1_i,
    input  logic [DATA_WIDTH-1:0] ReadData2_i,
    input  logic [REG_ADDR_W-1:0] Rs_i,
    input  logic [REG_ADDR_W-1:0] Rt_i,
    input  logic [REG_ADDR_W-1:0] Rd_i,
    input  logic [DATA_WIDTH-1:0] Imm_i,
    input  logic [DATA_WIDTH-1:0] PC4_i,
    input  logic                  RegWrite_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic                  MemtoReg_i,
    input  logic                  ALUSrc_i,
    input  logic                  RegDst_i,
    input  logic [ALU_OP_W-1:0]   ALUOp_i,
    input  logic                  ID_Valid_i,
    input  logic                  Flush_i,
    input  logic                  WB_RegWrite_i,
    input  logic [REG_ADDR_W-1:0] WB_WriteRegister_i,
    input  logic [DATA_WIDTH-1:0] WB_WriteData_i,
    output logic                  Stall_o,
    output logic [DATA_WIDTH-1:0] EX_ReadData1_o,
    output logic [DATA_WIDTH-1:0] EX_ReadData2_o,
    output logic [DATA_WIDTH-1:0] EX_Imm_o,
    output logic [DATA_WIDTH-1:0] EX_PC4_o,
    output logic [REG_ADDR_W-1:0] EX_Rs_o,
    output logic [REG_ADDR_W-1:0] EX_Rt_o,
    output logic [REG_ADDR_W-1:0] EX_WriteRegister_o,
    output logic                  EX_RegWrite_o,
    output logic                  EX_MemRead_o,
    output logic                  EX_MemWrite_o,
    output logic                  EX_MemtoReg_o,
    output logic                  EX_ALUSrc_o,
    output logic [ALU_OP_W-1:0]   EX_ALUOp_o,
    output logic                  EX_Valid_o,
    output logic [CNT_WIDTH-1:0]  StallCount_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    exCtrlT                exCtrl;
    logic [DATA_WIDTH-1:0] exData1, exData2, exImm, exPc4;
    logic [REG_ADDR_W-1:0] exRs, exRt, exWriteRegister;
    logic [CNT_WIDTH-1:0]  stallCount;

    logic                  stall;
    logic [DATA_WIDTH-1:0] d1, d2;

    id_ex_hazard_bypass #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hazardBypass (
        .exMemRead       (exCtrl.memRead),
        .exValid         (exCtrl.valid),
        .exWriteRegister (exWriteRegister),
        .idValid         (ID_Valid_i),
        .rs              (Rs_i),
        .rt              (Rt_i),
        .readData1       (ReadData1_i),
        .readData2       (ReadData2_i),
        .wbRegWrite      (WB_RegWrite_i),
        .wbWriteRegister (WB_WriteRegister_i),
        .wbWriteData     (WB_WriteData_i),
        .stall           (stall),
        .d1              (d1),
        .d2              (d2)
    );

    // Control bundle: a bubble clears every control bit. Flush is checked
    // first only for clarity; both flush and stall produce the same bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exCtrl <= '0;
        end else if (Flush_i || stall) begin
            exCtrl <= '0;
        end else begin
            exCtrl <= '{regWrite: RegWrite_i, memRead: MemRead_i,
                        memWrite: MemWrite_i, memtoReg: MemtoReg_i,
                        aluSrc: ALUSrc_i, aluOp: ALUOp_i, valid: ID_Valid_i};
        end
    end

    // Operands and register numbers hold through a bubble; they are only
    // meaningful while the control bundle is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exData1         <= '0;
            exData2         <= '0;
            exImm           <= '0;
            exPc4           <= '0;
            exRs            <= '0;
            exRt            <= '0;
            exWriteRegister <= '0;
        end else if (!(Flush_i || stall)) begin
            exData1         <= d1;
            exData2         <= d2;
            exImm           <= Imm_i;
            exPc4           <= PC4_i;
            exRs            <= Rs_i;
            exRt            <= Rt_i;
            exWriteRegister <= RegDst_i ? Rd_i : Rt_i;
        end
    end

    // Counts every stalled edge, including ones where a flush also fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCount <= '0;
        end else if (stall && (stallCount != '1)) begin
            stallCount <= stallCount + CNT_ONE;
        end
    end

    assign Stall_o            = stall;
    assign EX_ReadData1_o     = exData1;
    assign EX_ReadData2_o     = exData2;
    assign EX_Imm_o           = exImm;
    assign EX_PC4_o           = exPc4;
    assign EX_Rs_o            = exRs;
    assign EX_Rt_o            = exRt;
    assign EX_WriteRegister_o = exWriteRegister;
    assign EX_RegWrite_o      = exCtrl.regWrite;
    assign EX_MemRead_o       = exCtrl.memRead;
    assign EX_MemWrite_o      = exCtrl.memWrite;
    assign EX_MemtoReg_o      = exCtrl.memtoReg;
    assign EX_ALUSrc_o        = exCtrl.aluSrc;
    assign EX_ALUOp_o         = exCtrl.aluOp;
    assign EX_Valid_o         = exCtrl.valid;
    assign StallCount_o       = stallCount;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Bench for id_ex_stage: a main instance (CNT_WIDTH=16) and a second
//   instance with CNT_WIDTH=4 sharing the same stimulus, so the counter
//   saturation point can be reached quickly.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    // ---------------------------------------------------------------- signals
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] readData1, readData2, imm, pc4, wbWriteData;
    logic [4:0]  rs, rt, rd, wbWriteRegister;
    logic        regWrite, memRead, memWrite, memtoReg, aluSrc, regDst;
    logic [2:0]  aluOp;
    logic        idValid, flush, wbRegWrite;

    logic        stall, exRegWrite, exMemRead, exMemWrite, exMemtoReg, exAluSrc, exValid;
    logic [31:0] exRd1, exRd2, exImm, exPc4;
    logic [4:0]  exRs, exRt, exWr;
    logic [2:0]  exAluOp;
    logic [15:0] stallCount;

    logic        sStall, sRegWrite, sMemRead, sMemWrite, sMemtoReg, sAluSrc, sValid;
    logic [31:0] sRd1, sRd2, sImm, sPc4;
    logic [4:0]  sRs, sRt, sWr;
    logic [2:0]  sAluOp;
    logic [3:0]  sCount;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------ DUTs
    id_ex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .ReadData1_i(readData1), .ReadData2_i(readData2),
        .Rs_i(rs), .Rt_i(rt), .Rd_i(rd), .Imm_i(imm), .PC4_i(pc4),
        .RegWrite_i(regWrite), .MemRead_i(memRead), .MemWrite_i(memWrite),
        .MemtoReg_i(memtoReg), .ALUSrc_i(aluSrc), .RegDst_i(regDst),
        .ALUOp_i(aluOp), .ID_Valid_i(idValid), .Flush_i(flush),
        .WB_RegWrite_i(wbRegWrite), .WB_WriteRegister_i(wbWriteRegister),
        .WB_WriteData_i(wbWriteData),
        .Stall_o(stall),
        .EX_ReadData1_o(exRd1), .EX_ReadData2_o(exRd2), .EX_Imm_o(exImm), .EX_PC4_o(exPc4),
        .EX_Rs_o(exRs), .EX_Rt_o(exRt), .EX_WriteRegister_o(exWr),
        .EX_RegWrite_o(exRegWrite), .EX_MemRead_o(exMemRead), .EX_MemWrite_o(exMemWrite),
        .EX_MemtoReg_o(exMemtoReg), .EX_ALUSrc_o(exAluSrc), .EX_ALUOp_o(exAluOp),
        .EX_Valid_o(exValid), .StallCount_o(stallCount)
    );

    id_ex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) u_small (
        .clk(clk), .reset(reset),
        .ReadData1_i(readData1), .ReadData2_i(readData2),
        .Rs_i(rs), .Rt_i(rt), .Rd_i(rd), .Imm_i(imm), .PC4_i(pc4),
        .RegWrite_i(regWrite), .MemRead_i(memRead), .MemWrite_i(memWrite),
        .MemtoReg_i(memtoReg), .ALUSrc_i(aluSrc), .RegDst_i(regDst),
        .ALUOp_i(aluOp), .ID_Valid_i(idValid), .Flush_i(flush),
        .WB_RegWrite_i(wbRegWrite), .WB_WriteRegister_i(wbWriteRegister),
        .WB_WriteData_i(wbWriteData),
        .Stall_o(sStall),
        .EX_ReadData1_o(sRd1), .EX_ReadData2_o(sRd2), .EX_Imm_o(sImm), .EX_PC4_o(sPc4),
        .EX_Rs_o(sRs), .EX_Rt_o(sRt), .EX_WriteRegister_o(sWr),
        .EX_RegWrite_o(sRegWrite), .EX_MemRead_o(sMemRead), .EX_MemWrite_o(sMemWrite),
        .EX_MemtoReg_o(sMemtoReg), .EX_ALUSrc_o(sAluSrc), .EX_ALUOp_o(sAluOp),
        .EX_Valid_o(sValid), .StallCount_o(sCount)
    );

    // ------------------------------------------------------ clock and reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- model
    // Expected EX contents after each edge, derived from the stage's rules.
    typedef struct packed {
        logic        valid, regWrite, memRead, memWrite, memtoReg, aluSrc;
        logic [2:0]  aluOp;
        logic [4:0]  rs, rt, wr;
        logic [31:0] d1, d2, imm, pc4;
        logic [15:0] cnt16;
        logic [3:0]  cnt4;
    } exStateT;

    localparam int EXP_W = $bits(exStateT);
    logic [EXP_W-1:0] exp_q[$];
    exStateT modelEx = '0;
    exStateT cmpEx;
    int      stallTotal = 0;
    bit      modelHz;

    function automatic bit loadUse(input exStateT e);
        return e.valid && e.memRead && idValid && (e.wr != 5'd0) && ((e.wr == rs) || (e.wr == rt));
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] fileVal);
        if (wbRegWrite && wbWriteRegister != 5'd0 && wbWriteRegister == src) return wbWriteData;
        return fileVal;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            modelEx    = '0;
            stallTotal = 0;
        end else begin
            modelHz = loadUse(modelEx);
            if (modelHz) stallTotal = stallTotal + 1;
            if (flush || modelHz) begin
                modelEx.valid = 0; modelEx.regWrite = 0; modelEx.memRead = 0;
                modelEx.memWrite = 0; modelEx.memtoReg = 0; modelEx.aluOp = 3'd0;
            end else begin
                modelEx.valid = idValid; modelEx.regWrite = regWrite; modelEx.memRead = memRead;
                modelEx.memWrite = memWrite; modelEx.memtoReg = memtoReg; modelEx.aluSrc = aluSrc;
                modelEx.aluOp = aluOp; modelEx.rs = rs; modelEx.rt = rt;
                modelEx.wr = regDst ? rd : rt;
                modelEx.d1 = operand(rs, readData1);
                modelEx.d2 = operand(rt, readData2);
                modelEx.imm = imm; modelEx.pc4 = pc4;
            end
            modelEx.cnt16 = (stallTotal > 65535) ? 16'hFFFF : 16'(stallTotal);
            modelEx.cnt4  = (stallTotal > 15) ? 4'hF : 4'(stallTotal);
        end
        exp_q.push_back(modelEx);
    end

    // Asynchronous reset: the pending expectation becomes the cleared state.
    always @(negedge reset) begin
        modelEx    = '0;
        stallTotal = 0;
        exp_q.delete();
        exp_q.push_back(modelEx);
    end

    // ---------------------------------------------------------- scoreboard
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmpEx = exp_q.pop_front();
            checkVal("stall", {31'd0, stall}, {31'd0, loadUse(cmpEx)});
            checkVal("valid", {31'd0, exValid}, {31'd0, cmpEx.valid});
            checkVal("ctrl", {27'd0, exRegWrite, exMemRead, exMemWrite, exMemtoReg, exAluOp == 3'd0 ? 1'b0 : 1'b1},
                     {27'd0, cmpEx.regWrite, cmpEx.memRead, cmpEx.memWrite, cmpEx.memtoReg, cmpEx.aluOp == 3'd0 ? 1'b0 : 1'b1});
            checkVal("aluOp", {29'd0, exAluOp}, {29'd0, cmpEx.aluOp});
            checkVal("cnt16", {16'd0, stallCount}, {16'd0, cmpEx.cnt16});
            checkVal("cnt4", {28'd0, sCount}, {28'd0, cmpEx.cnt4});
            checkVal("sStall", {31'd0, sStall}, {31'd0, loadUse(cmpEx)});
            if (cmpEx.valid) begin
                checkVal("d1", exRd1, cmpEx.d1);
                checkVal("d2", exRd2, cmpEx.d2);
                checkVal("imm", exImm, cmpEx.imm);
                checkVal("pc4", exPc4, cmpEx.pc4);
                checkVal("regs", {17'd0, exRs, exRt, exWr}, {17'd0, cmpEx.rs, cmpEx.rt, cmpEx.wr});
                checkVal("aluSrc", {31'd0, exAluSrc}, {31'd0, cmpEx.aluSrc});
                checkVal("sValid", {31'd0, sValid}, {31'd0, cmpEx.valid});
            end
        end
    end

    // ------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        readData1 = 0; readData2 = 0; imm = 0; pc4 = 0;
        rs = 0; rt = 0; rd = 0;
        regWrite = 0; memRead = 0; memWrite = 0; memtoReg = 0; aluSrc = 0; regDst = 0;
        aluOp = 0; idValid = 0; flush = 0;
        wbRegWrite = 0; wbWriteRegister = 0; wbWriteData = 0;
    endtask

    task automatic driveAlu(input logic [4:0] s, t, d, input logic [31:0] v1, v2);
        rs = s; rt = t; rd = d; readData1 = v1; readData2 = v2;
        imm = 32'h0; pc4 = 32'h0000_0404;
        regWrite = 1; memRead = 0; memWrite = 0; memtoReg = 0; aluSrc = 0; regDst = 1;
        aluOp = ALU_OP_RTYPE; idValid = 1;
    endtask

    task automatic driveLoad(input logic [4:0] base, dst, input logic [31:0] off);
        rs = base; rt = dst; rd = 5'd0; readData1 = 32'h0000_0100; readData2 = 32'h0;
        imm = off; pc4 = 32'h0000_0400;
        regWrite = 1; memRead = 1; memWrite = 0; memtoReg = 1; aluSrc = 1; regDst = 0;
        aluOp = ALU_OP_ADD; idValid = 1;
    endtask

    task automatic driveWb(input logic en, input logic [4:0] r, input logic [31:0] data);
        wbRegWrite = en; wbWriteRegister = r; wbWriteData = data;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        checkVal("rst_valid", {31'd0, exValid}, 32'd0);
        checkVal("rst_cnt", {16'd0, stallCount}, 32'd0);
        checkVal("rst_stall", {31'd0, stall}, 32'd0);

        // Normal capture with rd destination.
        driveAlu(5'd8, 5'd2, 5'd10, 32'h11, 32'h22);
        tick();
        checkVal("cap_rd1", exRd1, 32'h11);
        checkVal("cap_wr", {27'd0, exWr}, 32'd10);
        checkVal("cap_valid", {31'd0, exValid}, 32'd1);

        // Write-back bypass into rt, then a write to r0 that must not bypass.
        driveAlu(5'd3, 5'd9, 5'd4, 32'h33, 32'h0);
        driveWb(1'b1, 5'd9, 32'hDEAD);
        tick();
        checkVal("byp_rd2", exRd2, 32'hDEAD);
        checkVal("byp_rd1", exRd1, 32'h33);
        driveAlu(5'd3, 5'd0, 5'd4, 32'h33, 32'h0);
        driveWb(1'b1, 5'd0, 32'hDEAD);
        tick();
        checkVal("byp_r0", exRd2, 32'h0);
        driveWb(1'b0, 5'd0, 32'h0);

        // Load-use: lw r16 followed by a reader of r16.
        driveLoad(5'd1, 5'd16, 32'h8);
        tick();
        checkVal("lu_memread", {31'd0, exMemRead}, 32'd1);
        driveAlu(5'd16, 5'd2, 5'd3, 32'h5, 32'h6);
        #1;
        checkVal("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        checkVal("lu_bubble_valid", {31'd0, exValid}, 32'd0);
        checkVal("lu_bubble_rw", {31'd0, exRegWrite}, 32'd0);
        checkVal("lu_count", {16'd0, stallCount}, 32'd1);
        checkVal("lu_stall_end", {31'd0, stall}, 32'd0);
        tick();
        checkVal("lu_capture_valid", {31'd0, exValid}, 32'd1);
        checkVal("lu_capture_rs", {27'd0, exRs}, 32'd16);
        checkVal("lu_capture_rd1", exRd1, 32'h5);

        // Flush together with a load-use stall: bubble, stall still counted.
        driveLoad(5'd1, 5'd16, 32'h8);
        tick();
        driveAlu(5'd16, 5'd2, 5'd3, 32'h5, 32'h6);
        flush = 1;
        #1;
        checkVal("fl_stall", {31'd0, stall}, 32'd1);
        tick();
        checkVal("fl_valid", {31'd0, exValid}, 32'd0);
        checkVal("fl_memread", {31'd0, exMemRead}, 32'd0);
        checkVal("fl_count", {16'd0, stallCount}, 32'd2);
        flush = 0;
        tick();
        checkVal("fl_next_valid", {31'd0, exValid}, 32'd1);

        // Asynchronous reset between edges with a load sitting in EX.
        driveLoad(5'd1, 5'd16, 32'h8);
        tick();
        #1;
        reset = 0;
        #1;
        checkVal("arst_valid", {31'd0, exValid}, 32'd0);
        checkVal("arst_memread", {31'd0, exMemRead}, 32'd0);
        checkVal("arst_rw", {31'd0, exRegWrite}, 32'd0);
        checkVal("arst_rd1", exRd1, 32'd0);
        checkVal("arst_wr", {27'd0, exWr}, 32'd0);
        checkVal("arst_cnt", {16'd0, stallCount}, 32'd0);
        checkVal("arst_stall", {31'd0, stall}, 32'd0);
        tick();
        reset = 1;
        clearInputs();
        tick();

        // Twenty load-use stalls: 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            driveLoad(5'd1, 5'd16, 32'(i));
            tick();
            driveAlu(5'd16, 5'd2, 5'd3, 32'(i), 32'h6);
            tick();
            tick();
        end
        checkVal("sat_cnt4", {28'd0, sCount}, 32'd15);
        checkVal("sat_cnt16", {16'd0, stallCount}, 32'd20);

        // Mixed traffic over a small register set to hit hazards and bypasses.
        for (int i = 0; i < 80; i++) begin
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
            readData1 = $urandom; readData2 = $urandom; imm = $urandom; pc4 = 32'($urandom_range(0, 4095)) << 2;
            regWrite = 1'($urandom_range(0, 1)); memRead = 1'($urandom_range(0, 1));
            memWrite = 1'($urandom_range(0, 1)); memtoReg = 1'($urandom_range(0, 1));
            aluSrc = 1'($urandom_range(0, 1)); regDst = 1'($urandom_range(0, 1));
            aluOp = 3'($urandom_range(0, 7)); idValid = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 7) == 0);
            driveWb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            tick();
        end

        clearInputs();
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
